down_timer: RTL
===============

# down_timer

Parametrised countdown timer, successor to the 4-bit latch/decrement counter. Adds configurable count width, a programmable prescaler, one-shot and auto-reload modes, start/stop control, a single-cycle expiry pulse and a sticky expiry flag. Sits beside peripheral control logic as a general-purpose interval/timeout generator driven from the system clock.

## Interface
- WIDTH, 4: count and load-value width in bits (≥2).
- PRESCALE_WIDTH, 8: prescaler compare width; one count tick every prescale+1 enabled cycles.

- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- load_value  in  WIDTH  value captured on latch.
- latch  in  1  load count and reload register from load_value; stop timer.
- start  in  1  begin counting.
- stop  in  1  halt counting, hold count.
- dec  in  1  count enable; low pauses prescaler and count without leaving RUN.
- auto_reload  in  1  1 = periodic, 0 = one-shot; sampled at each expiry.
- prescale  in  PRESCALE_WIDTH  divider setting, sampled live.
- clear_flag  in  1  clear expired_flag.
- count  out  WIDTH  current count register.
- zero  out  1  count == 0 (decoded from register, no extra latency).
- expire  out  1  registered one-cycle pulse on each expiry.
- expired_flag  out  1  sticky expiry indicator.
- running  out  1  state == RUN.

## Operation
- Registers: count, reload (WIDTH), pre_cnt (PRESCALE_WIDTH), state, expire, expired_flag.
- Reset values: count 0, reload 0, pre_cnt 0, state IDLE, expire 0, expired_flag 0; hence running 0, zero 1.
- States IDLE, RUN, DONE.
- Control priority per edge: latch > stop > start > tick.
- latch (any state): count ← load_value, reload ← load_value, pre_cnt ← 0, state ← IDLE.
- stop: RUN → IDLE, count held, pre_cnt ← 0; no effect elsewhere.
- start from IDLE: if count ≠ 0 → RUN, pre_cnt ← 0; if count = 0 → stays IDLE.
- start from DONE: if reload ≠ 0 → count ← reload, pre_cnt ← 0, RUN; else stays DONE.
- start in RUN: ignored (no restart of prescaler).
- Tick: in RUN with dec = 1, if pre_cnt ≥ prescale → tick, pre_cnt ← 0; else pre_cnt ← pre_cnt + 1. dec = 0 holds pre_cnt. The ≥ compare guarantees a tick when prescale is lowered below pre_cnt mid-count.
- On tick with count > 1: count ← count − 1.
- On tick with count = 1 (expiry): expire ← 1 for one cycle; expired_flag ← 1.
  - auto_reload = 1: count ← reload, stay RUN (count never shows 0).
  - auto_reload = 0: count ← 0, state ← DONE.
- expire is 0 on every edge without an expiry.
- clear_flag clears expired_flag; simultaneous expiry wins (flag stays 1).
- Arithmetic modulo 2^WIDTH never wraps: count never decrements below 0, RUN is never entered with count 0.

## Timing
- All outputs registered or decoded from registers; no input-to-output combinational path.
- latch/start/stop take effect at the edge they are sampled on; running/count visible after that edge.
- Start sampled at edge k with dec held high: first decrement at edge k + prescale + 1; one-shot expiry (count L) at edge k + L·(prescale+1), expire high for the following cycle.
- Auto-reload period = reload·(prescale+1) enabled cycles; expire pulses exactly once per period.
- dec low for n cycles extends all later events by n cycles.
- reset_n low mid-count: all registers to reset values immediately, independent of clock; expire drops without completing its cycle.

## Test plan
- Reset: assert reset_n low mid-RUN between edges → count 0, zero 1, running 0, expire 0, expired_flag 0 before next edge.
- One-shot, WIDTH 4, load 15, prescale 0, start, dec high → count 14…0 on 15 consecutive edges, single expire pulse, state DONE, expired_flag 1.
- Prescale 2, load 3, start → decrements every 3 cycles, expire 9 cycles after start edge; drop dec 4 cycles mid-run → expire 13 cycles after start.
- Auto-reload, load 4, prescale 0 → count 3,2,1,4,3,… ; expire every 4 cycles for ≥3 periods; clear_flag coincident with expire leaves flag 1.
- Priority: latch and start same edge → IDLE with new value; stop mid-run holds count 7, start resumes 7→6 after prescale+1 cycles.
- Boundaries: start with count 0 → stays IDLE; start from DONE with reload 0 → stays DONE; WIDTH 8 load 255 counts fully to expiry.

Source files
------------

// File: rtl/down_timer.sv
// Countdown timer with prescaler, one-shot/auto-reload modes and expiry reporting.
// Next-state logic resolves latch > stop > start > tick; all outputs come from registers.
module down_timer #(
    parameter int WIDTH          = 4,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [WIDTH-1:0]          load_value,
    input  logic                      latch,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      dec,
    input  logic                      auto_reload,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      clear_flag,
    output logic [WIDTH-1:0]          count,
    output logic                      zero,
    output logic                      expire,
    output logic                      expired_flag,
    output logic                      running
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                    state_q, state_d;
    logic [WIDTH-1:0]          count_q, count_d;
    logic [WIDTH-1:0]          reload_q, reload_d;
    logic [PRESCALE_WIDTH-1:0] pre_q, pre_d;
    logic                      expire_q, expire_d;
    logic                      flag_q, flag_d;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        pre_d    = pre_q;
        expire_d = 1'b0;
        flag_d   = flag_q & ~clear_flag;

        if (latch) begin
            count_d  = load_value;
            reload_d = load_value;
            pre_d    = '0;
            state_d  = IDLE;
        end else if (stop && state_q == RUN) begin
            state_d = IDLE;
            pre_d   = '0;
        end else if (start && state_q == IDLE) begin
            if (count_q != '0) begin
                state_d = RUN;
                pre_d   = '0;
            end
        end else if (start && state_q == DONE) begin
            if (reload_q != '0) begin
                count_d = reload_q;
                pre_d   = '0;
                state_d = RUN;
            end
        end else if (state_q == RUN && dec) begin
            // >= so that lowering prescale below pre_cnt still produces a tick
            if (pre_q >= prescale) begin
                pre_d = '0;
                if (count_q > WIDTH'(1)) begin
                    count_d = count_q - WIDTH'(1);
                end else begin
                    expire_d = 1'b1;
                    flag_d   = 1'b1;
                    if (auto_reload) begin
                        count_d = reload_q;
                    end else begin
                        count_d = '0;
                        state_d = DONE;
                    end
                end
            end else begin
                pre_d = pre_q + PRESCALE_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            pre_q    <= '0;
            expire_q <= 1'b0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            pre_q    <= pre_d;
            expire_q <= expire_d;
            flag_q   <= flag_d;
        end
    end

    assign count        = count_q;
    assign zero         = (count_q == '0);
    assign expire       = expire_q;
    assign expired_flag = flag_q;
    assign running      = (state_q == RUN);

endmodule
